// File: rtl/exc_unit_pkg.sv
// Shared types and CP0 field positions for the MEM-stage exception unit.
package exc_unit_pkg;

    // CP0 Status / Cause bit positions
    localparam int unsigned CP0_SR_IE  = 0;
    localparam int unsigned CP0_SR_EXL = 1;
    localparam int unsigned CP0_IM_LO  = 8;
    localparam int unsigned CP0_IM_HI  = 15;
    localparam int unsigned CP0_IP_LO  = 8;
    localparam int unsigned CP0_IP_HI  = 15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exccode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } exc_state_t;

    // Source of the BadVAddr value for the selected exception
    typedef enum logic [1:0] {
        BVA_NONE = 2'd0,
        BVA_PC   = 2'd1,
        BVA_ADDR = 2'd2
    } bva_sel_t;

    // Interrupt enabled, not at exception level, and some unmasked IP pending
    function automatic logic int_pending(input logic [31:0] status,
                                         input logic [31:0] cause);
        return status[CP0_SR_IE] & ~status[CP0_SR_EXL] &
               (|(cause[CP0_IP_HI:CP0_IP_LO] & status[CP0_IM_HI:CP0_IM_LO]));
    endfunction

endpackage

// File: rtl/exc_unit_if.sv
// Pipeline/CP0 facing signal bundle of the exception unit.
interface exc_unit_if;

    logic        m_stall;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_is_bd;
    logic        m_adel_if;
    logic        m_ri;
    logic        m_ov;
    logic        m_syscall;
    logic        m_break;
    logic        m_adel_ld;
    logic        m_ades_st;
    logic        m_eret;
    logic [31:0] m_addr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;

    logic        is_valid_exc;
    logic [31:0] epc_wdata;
    logic        cause_bd_wdata;
    logic [4:0]  cause_exccode_wdata;
    logic        badvaddr_wen;
    logic [31:0] badvaddr_wdata;
    logic        eret_commit;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Pipeline / CP0 side
    modport master (
        output m_stall, m_valid, m_pc, m_is_bd, m_adel_if, m_ri, m_ov,
               m_syscall, m_break, m_adel_ld, m_ades_st, m_eret, m_addr,
               cp0_status, cp0_cause, cp0_epc,
        input  is_valid_exc, epc_wdata, cause_bd_wdata, cause_exccode_wdata,
               badvaddr_wen, badvaddr_wdata, eret_commit, flush,
               redirect_valid, redirect_pc
    );

    // Exception unit side
    modport slave (
        input  m_stall, m_valid, m_pc, m_is_bd, m_adel_if, m_ri, m_ov,
               m_syscall, m_break, m_adel_ld, m_ades_st, m_eret, m_addr,
               cp0_status, cp0_cause, cp0_epc,
        output is_valid_exc, epc_wdata, cause_bd_wdata, cause_exccode_wdata,
               badvaddr_wen, badvaddr_wdata, eret_commit, flush,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the single highest-priority event.
module exc_prio_enc
    import exc_unit_pkg::*;
(
    input  logic     valid,
    input  logic     int_req,
    input  logic     adel_if,
    input  logic     ri,
    input  logic     ov,
    input  logic     sys,
    input  logic     bp,
    input  logic     adel_ld,
    input  logic     ades_st,
    output logic     exc_valid,
    output exccode_t exccode,
    output bva_sel_t bva_sel
);

    // Fixed priority: Int > AdEL-fetch > RI > Ov > Sys > Bp > AdEL-load > AdES-store
    always_comb begin
        exc_valid = 1'b0;
        exccode   = EXC_INT;
        bva_sel   = BVA_NONE;
        if (valid) begin
            exc_valid = 1'b1;
            if (int_req) begin
                exccode = EXC_INT;
            end else if (adel_if) begin
                exccode = EXC_ADEL;
                bva_sel = BVA_PC;
            end else if (ri) begin
                exccode = EXC_RI;
            end else if (ov) begin
                exccode = EXC_OV;
            end else if (sys) begin
                exccode = EXC_SYS;
            end else if (bp) begin
                exccode = EXC_BP;
            end else if (adel_ld) begin
                exccode = EXC_ADEL;
                bva_sel = BVA_ADDR;
            end else if (ades_st) begin
                exccode = EXC_ADES;
                bva_sel = BVA_ADDR;
            end else begin
                exc_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/exc_unit.sv
// MEM-stage exception/interrupt arbiter driving CP0 commit, flush and redirect.
module exc_unit
    import exc_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input logic       clk,
    input logic       rst,
    exc_unit_if.slave bus
);

    exc_state_t  state_d, state_q;
    logic        int_req_d, int_req_q;
    exccode_t    code_d, code_q;
    logic [31:0] epc_d, epc_q;
    logic        bd_d, bd_q;
    logic        bva_wen_d, bva_wen_q;
    logic [31:0] bva_d, bva_q;
    logic        is_exc_d, is_exc_q;
    logic [31:0] redir_d, redir_q;

    logic        enc_valid;
    exccode_t    enc_code;
    bva_sel_t    enc_bva_sel;

    logic [31:0] live_epc;
    logic        live_bva_wen;
    logic [31:0] live_bva;
    logic        eret_evt;

    logic        o_is_valid_exc;
    logic [31:0] o_epc;
    logic        o_bd;
    exccode_t    o_code;
    logic        o_bva_wen;
    logic [31:0] o_bva;
    logic        o_eret_commit;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    logic        unused_cp0_bits;
    assign unused_cp0_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                               bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

    exc_prio_enc u_prio (
        .valid     (bus.m_valid),
        .int_req   (int_req_q),
        .adel_if   (bus.m_adel_if),
        .ri        (bus.m_ri),
        .ov        (bus.m_ov),
        .sys       (bus.m_syscall),
        .bp        (bus.m_break),
        .adel_ld   (bus.m_adel_ld),
        .ades_st   (bus.m_ades_st),
        .exc_valid (enc_valid),
        .exccode   (enc_code),
        .bva_sel   (enc_bva_sel)
    );

    // Commit fields computed from the live MEM instruction
    always_comb begin
        live_epc     = bus.m_is_bd ? (bus.m_pc - 32'd4) : bus.m_pc;
        live_bva_wen = (enc_bva_sel != BVA_NONE);
        live_bva     = '0;
        if (enc_bva_sel == BVA_PC)   live_bva = bus.m_pc;
        if (enc_bva_sel == BVA_ADDR) live_bva = bus.m_addr;
        eret_evt     = bus.m_valid & bus.m_eret & ~enc_valid;
    end

    // Next-state, latch updates and outputs
    always_comb begin
        state_d   = state_q;
        int_req_d = int_pending(bus.cp0_status, bus.cp0_cause);
        code_d    = code_q;
        epc_d     = epc_q;
        bd_d      = bd_q;
        bva_wen_d = bva_wen_q;
        bva_d     = bva_q;
        is_exc_d  = is_exc_q;
        redir_d   = redir_q;

        o_is_valid_exc   = 1'b0;
        o_epc            = '0;
        o_bd             = 1'b0;
        o_code           = EXC_INT;
        o_bva_wen        = 1'b0;
        o_bva            = '0;
        o_eret_commit    = 1'b0;
        o_flush          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;

        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    o_is_valid_exc = 1'b1;
                    o_epc          = live_epc;
                    o_bd           = bus.m_is_bd;
                    o_code         = enc_code;
                    o_bva_wen      = live_bva_wen;
                    o_bva          = live_bva;
                    code_d         = enc_code;
                    epc_d          = live_epc;
                    bd_d           = bus.m_is_bd;
                    bva_wen_d      = live_bva_wen;
                    bva_d          = live_bva;
                    is_exc_d       = 1'b1;
                    redir_d        = EXC_VECTOR;
                    state_d        = bus.m_stall ? HOLD : FLUSH;
                end else if (eret_evt) begin
                    o_eret_commit = 1'b1;
                    is_exc_d      = 1'b0;
                    redir_d       = bus.cp0_epc;
                    state_d       = bus.m_stall ? HOLD : FLUSH;
                end
            end
            HOLD: begin
                // Replay from the latch so a vanished IP still commits
                o_is_valid_exc = is_exc_q;
                o_eret_commit  = ~is_exc_q;
                if (is_exc_q) begin
                    o_epc     = epc_q;
                    o_bd      = bd_q;
                    o_code    = code_q;
                    o_bva_wen = bva_wen_q;
                    o_bva     = bva_q;
                end
                if (!bus.m_stall) begin
                    if (!is_exc_q) redir_d = bus.cp0_epc;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                o_flush          = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = redir_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every output in the same cycle, including mid-HOLD/FLUSH
        if (rst) begin
            o_is_valid_exc   = 1'b0;
            o_epc            = '0;
            o_bd             = 1'b0;
            o_code           = EXC_INT;
            o_bva_wen        = 1'b0;
            o_bva            = '0;
            o_eret_commit    = 1'b0;
            o_flush          = 1'b0;
            o_redirect_valid = 1'b0;
            o_redirect_pc    = '0;
        end
    end

    // State and latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            code_q    <= EXC_INT;
            epc_q     <= '0;
            bd_q      <= 1'b0;
            bva_wen_q <= 1'b0;
            bva_q     <= '0;
            is_exc_q  <= 1'b0;
            redir_q   <= '0;
        end else begin
            state_q   <= state_d;
            int_req_q <= int_req_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            bd_q      <= bd_d;
            bva_wen_q <= bva_wen_d;
            bva_q     <= bva_d;
            is_exc_q  <= is_exc_d;
            redir_q   <= redir_d;
        end
    end

    assign bus.is_valid_exc        = o_is_valid_exc;
    assign bus.epc_wdata           = o_epc;
    assign bus.cause_bd_wdata      = o_bd;
    assign bus.cause_exccode_wdata = o_code;
    assign bus.badvaddr_wen        = o_bva_wen;
    assign bus.badvaddr_wdata      = o_bva;
    assign bus.eret_commit         = o_eret_commit;
    assign bus.flush               = o_flush;
    assign bus.redirect_valid      = o_redirect_valid;
    assign bus.redirect_pc         = o_redirect_pc;

endmodule

// File: doc/exc_unit.md
Name: exc_unit

Overview:
- MEM-stage exception/interrupt arbiter sitting directly upstream of the CP0 register file.
- Consumes per-instruction exception flags from the pipeline and live CP0 Status/Cause/EPC.
- Picks the single highest-priority event and drives the CP0 commit signals (is_valid_exc, EPC, BD, ExcCode, BadVAddr).
- After commit, issues a one-cycle pipeline flush and PC redirect to the exception vector, or to EPC for ERET.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_stall  in  1  MEM stage stalled; CP0 ignores commits while high
- m_valid  in  1  MEM holds a real instruction
- m_pc  in  32  PC of MEM instruction
- m_is_bd  in  1  MEM instruction is in a branch delay slot
- m_adel_if  in  1  fetch address error
- m_ri  in  1  reserved instruction
- m_ov  in  1  arithmetic overflow
- m_syscall  in  1  SYSCALL
- m_break  in  1  BREAK
- m_adel_ld  in  1  load address error
- m_ades_st  in  1  store address error
- m_eret  in  1  ERET in MEM
- m_addr  in  32  data address of load/store
- cp0_status  in  32  live Status
- cp0_cause  in  32  live Cause
- cp0_epc  in  32  live EPC
- is_valid_exc  out  1  exception commit request to CP0
- epc_wdata  out  32  EPC value
- cause_bd_wdata  out  1  Cause.BD value
- cause_exccode_wdata  out  5  ExcCode
- badvaddr_wen  out  1  write BadVAddr this commit
- badvaddr_wdata  out  32  BadVAddr value
- eret_commit  out  1  ERET retired (integration clears Status.EXL)
- flush  out  1  kill IF..MEM
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  32  redirect target

Behaviour:
- Reset: all outputs 0; FSM to IDLE; int_req_q = 0; latches cleared.
- Interrupt request:
  - int_req_q <= Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]), registered every cycle.
  - An interrupt is taken only on a cycle with m_valid = 1.
- Priority, highest first, with ExcCode:
  - Int 0x00
  - AdEL-fetch 0x04
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - AdEL-load 0x04
  - AdES-store 0x05
- Any exception or interrupt beats m_eret.
- Commit fields:
  - epc_wdata = m_is_bd ? m_pc-4 : m_pc
  - cause_bd_wdata = m_is_bd
- BadVAddr:
  - AdEL-fetch: badvaddr_wen = 1, badvaddr_wdata = m_pc.
  - AdEL-load / AdES-store: badvaddr_wen = 1, badvaddr_wdata = m_addr.
  - All other codes: badvaddr_wen = 0.
- FSM states IDLE, HOLD, FLUSH.
- IDLE:
  - Event detected with m_stall = 0: drive commit outputs combinationally this cycle; next state FLUSH.
  - Event detected with m_stall = 1: drive commit outputs; latch code, EPC, BD, BadVAddr and event type; next state HOLD.
- HOLD:
  - Outputs come from the latch, so an interrupt whose IP drops later is still taken.
  - Stay in HOLD while m_stall = 1.
  - First cycle with m_stall = 0 is the commit cycle; next state FLUSH.
- FLUSH (exactly 1 cycle):
  - flush = 1, redirect_valid = 1.
  - redirect_pc = EXC_VECTOR for exceptions, or EPC captured at ERET commit.
  - is_valid_exc and eret_commit are forced 0; all m_* inputs are ignored because the MEM instruction is being killed.
  - Next state IDLE.
- ERET (no exception present):
  - Same stall and hold rules as exceptions.
  - eret_commit = 1 on the commit cycle; is_valid_exc = 0.
  - cp0_epc is captured on the commit cycle.
- m_valid = 0 in IDLE: no outputs asserted; int_req_q stays pending.
- rst asserted in HOLD or FLUSH: go to IDLE at once; no flush is issued.
- Only one event is outstanding at a time; new events are ignored outside IDLE.

Decomposition:
- Shared package cpu_defs additions:
  - exccode_t (5-bit enum: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV)
  - exc_state_t (IDLE/HOLD/FLUSH)
  - CP0 bit-position constants for IE, EXL, IM, IP
- One natural sub-module, exc_prio_enc: purely combinational priority encoder from flags plus int_req_q to {valid, exccode, badvaddr_sel}.

Test Plan:
- Overflow, no stall:
  - Stimulus: m_valid = 1, m_pc = 0xBFC0_1000, m_ov = 1, m_stall = 0.
  - Response: same cycle is_valid_exc = 1, exccode = 0x0C, epc = 0xBFC0_1000, badvaddr_wen = 0.
  - Next cycle: flush = 1, redirect_pc = 0xBFC0_0380 for 1 cycle.
- Delay-slot store AdES:
  - Stimulus: m_is_bd = 1, m_pc = 0x8000_0014, m_ades_st = 1, m_addr = 0x8000_0101.
  - Response: epc = 0x8000_0010, BD = 1, code = 0x05, badvaddr_wdata = 0x8000_0101.
- Interrupt under stall:
  - Stimulus: Status = 0x0000_0401, Cause IP2 set one cycle, then cleared; m_stall = 1 for 3 cycles.
  - Response: HOLD keeps is_valid_exc = 1 with code 0x00; commit on the first unstalled cycle; flush the cycle after.
- Priority:
  - Stimulus: m_adel_if = 1, m_ri = 1, m_eret = 1 together, with m_pc = 0x0000_0003.
  - Response: code 0x04, badvaddr = 0x0000_0003, eret_commit = 0.
- ERET:
  - Stimulus: cp0_epc = 0x8000_2000, m_eret = 1, no stall.
  - Response: eret_commit = 1, is_valid_exc = 0; next cycle redirect_pc = 0x8000_2000, flush = 1.
- Reset in HOLD:
  - Stimulus: hold Sys under stall, then assert rst for 1 cycle.
  - Response: all outputs 0; no flush or redirect afterwards.
